// File: rtl/packet_fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port between several
// packet sources in the FIFO write clock domain.
module packet_fifo_write_arbiter #(
  parameter int WIDTH           = 8,
  parameter int REQUESTERS      = 4,
  parameter int REQUESTERS_LOG2 = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [REQUESTERS-1:0]         request_valid,
  input  logic [REQUESTERS-1:0]         request_last,
  input  logic [REQUESTERS*WIDTH-1:0]   request_data,
  output logic [REQUESTERS-1:0]         request_ready,
  output logic                          grant_valid,
  output logic [REQUESTERS_LOG2-1:0]    grant_index,
  output logic                          fifo_write_enable,
  output logic [WIDTH-1:0]              fifo_write_data,
  input  logic                          fifo_full
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam int CW = REQUESTERS_LOG2 + 1;
  localparam logic [CW-1:0] REQ_COUNT = CW'(REQUESTERS);
  localparam logic [REQUESTERS_LOG2-1:0] LAST_INDEX = REQUESTERS_LOG2'(REQUESTERS - 1);

  state_t                     state_r;
  state_t                     state_next_s;
  logic [REQUESTERS_LOG2-1:0] grant_index_r;
  logic [REQUESTERS_LOG2-1:0] pointer_r;
  logic [REQUESTERS_LOG2-1:0] pointer_after_s;
  logic [REQUESTERS_LOG2-1:0] select_index_s;
  logic                       select_found_s;
  logic [CW-1:0]              candidate_s;
  logic                       grantee_valid_s;
  logic                       grantee_last_s;
  logic [WIDTH-1:0]           grantee_data_s;
  logic                       transfer_s;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    select_found_s = 1'b0;
    select_index_s = {REQUESTERS_LOG2{1'b0}};
    candidate_s    = {CW{1'b0}};
    for (int k = 0; k < REQUESTERS; k++) begin
      candidate_s = {1'b0, pointer_r} + CW'(k);
      candidate_s = (candidate_s >= REQ_COUNT) ? (candidate_s - REQ_COUNT) : candidate_s;
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!select_found_s && request_valid[i] && (candidate_s == CW'(i))) begin
          select_found_s = 1'b1;
          select_index_s = REQUESTERS_LOG2'(i);
        end else begin
          select_found_s = select_found_s;
        end
      end
    end
  end

  assign pointer_after_s = (grant_index_r == LAST_INDEX) ? {REQUESTERS_LOG2{1'b0}}
                                                         : grant_index_r + REQUESTERS_LOG2'(1);

  // State, grant index and priority pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_index_r <= {REQUESTERS_LOG2{1'b0}};
      pointer_r     <= {REQUESTERS_LOG2{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == IDLE) && !flush && select_found_s) begin
        grant_index_r <= select_index_s;
      end
      // An aborted grantee also loses priority so it cannot starve the others.
      if ((state_r == LOCKED) && (flush || (transfer_s && grantee_last_s))) begin
        pointer_r <= pointer_after_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = select_found_s ? LOCKED : IDLE;
        LOCKED:  state_next_s = (transfer_s && grantee_last_s) ? IDLE : LOCKED;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Output logic: grantee mux, ready, zero-latency write path.
  always_comb begin
    grantee_valid_s = 1'b0;
    grantee_last_s  = 1'b0;
    grantee_data_s  = {WIDTH{1'b0}};
    request_ready   = {REQUESTERS{1'b0}};
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_index_r == REQUESTERS_LOG2'(i)) begin
        grantee_valid_s  = request_valid[i];
        grantee_last_s   = request_last[i];
        grantee_data_s   = request_data[i*WIDTH +: WIDTH];
        request_ready[i] = (state_r == LOCKED) && !fifo_full && !flush && !reset;
      end else begin
        request_ready[i] = 1'b0;
      end
    end
    transfer_s        = (state_r == LOCKED) && grantee_valid_s && !fifo_full && !flush && !reset;
    fifo_write_enable = transfer_s;
    fifo_write_data   = (state_r == LOCKED) ? grantee_data_s : {WIDTH{1'b0}};
  end

  assign grant_valid = (state_r == LOCKED);
  assign grant_index = grant_index_r;

endmodule

// File: tb/tb_packet_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized packets against a
// packet-level round-robin reference model.
module tb_packet_fifo_write_arbiter;
  localparam int W = 8;
  localparam int R = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset, flush, fifo_full;
  logic [R-1:0]   request_valid, request_last, request_ready;
  logic [R*W-1:0] request_data;
  logic           grant_valid, fifo_write_enable;
  logic [1:0]     grant_index;
  logic [W-1:0]   fifo_write_data;

  logic [2:0]     v3, l3, rdy3;
  logic [23:0]    d3;
  logic           gv3, we3;
  logic [1:0]     gi3;
  logic [7:0]     wd3;

  packet_fifo_write_arbiter #(.WIDTH(W), .REQUESTERS(R)) u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .request_valid(request_valid), .request_last(request_last), .request_data(request_data),
    .request_ready(request_ready), .grant_valid(grant_valid), .grant_index(grant_index),
    .fifo_write_enable(fifo_write_enable), .fifo_write_data(fifo_write_data), .fifo_full(fifo_full)
  );

  packet_fifo_write_arbiter #(.WIDTH(8), .REQUESTERS(3)) u_dut3 (
    .clock(clock), .reset(reset), .flush(1'b0),
    .request_valid(v3), .request_last(l3), .request_data(d3),
    .request_ready(rdy3), .grant_valid(gv3), .grant_index(gi3),
    .fifo_write_enable(we3), .fifo_write_data(wd3), .fifo_full(1'b0)
  );

  // Per-requester beat lists and consumption heads
  logic [7:0] bd [R][128];
  bit         bl [R][128];
  int         bn [R];
  int         bh [R];

  // Per-cycle log of DUT outputs
  logic       lw   [0:511];
  logic [7:0] ld   [0:511];
  logic       lgv  [0:511];
  logic [1:0] lgi  [0:511];
  logic [3:0] lrdy [0:511];
  int cyc;
  logic       last_we;
  logic [7:0] last_d;
  logic [1:0] last_gi;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic clear_q();
    for (int i = 0; i < R; i++) begin bn[i] = 0; bh[i] = 0; end
  endtask

  task automatic add_pkt(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      bd[r][bn[r]] = base + 8'(k);
      bl[r][bn[r]] = (k == len - 1);
      bn[r]++;
    end
  endtask

  task automatic cycle(input logic full, input logic fl);
    logic [R-1:0] acc;
    for (int i = 0; i < R; i++) begin
      request_valid[i]       = (bh[i] < bn[i]);
      request_last[i]        = request_valid[i] ? bl[i][bh[i]] : 1'b0;
      request_data[i*W +: W] = request_valid[i] ? bd[i][bh[i]] : 8'h00;
    end
    fifo_full = full;
    flush     = fl;
    #5;
    if (cyc < 512) begin
      lw[cyc] = fifo_write_enable; ld[cyc] = fifo_write_data;
      lgv[cyc] = grant_valid; lgi[cyc] = grant_index; lrdy[cyc] = request_ready;
    end
    last_we = fifo_write_enable; last_d = fifo_write_data; last_gi = grant_index;
    n_cmp++;
    if ($countones(request_ready) > 1) begin
      n_bad++; $display("FAIL ready_onehot: got %b want at most one bit", request_ready);
    end
    n_cmp++;
    if (fifo_write_enable && (fifo_full || flush)) begin
      n_bad++; $display("FAIL write_blocked: got we=1 with full=%0b flush=%0b want we=0", fifo_full, flush);
    end
    acc = request_ready & request_valid;
    cyc++;
    @(posedge clock); #1;
    for (int i = 0; i < R; i++) if (acc[i]) bh[i]++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle(1'b0, 1'b0);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    clear_q();
    for (int i = 0; i < R; i++) add_pkt(i, 1, 8'h10 + 8'(i));
    cyc = 0;
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n_cmp++; if (lgv[1] !== 1'b0)   begin n_bad++; $display("FAIL reset_gv: got %b want 0", lgv[1]); end
    n_cmp++; if (lrdy[1] !== 4'b0)  begin n_bad++; $display("FAIL reset_ready: got %b want 0000", lrdy[1]); end
    n_cmp++; if (lw[1] !== 1'b0)    begin n_bad++; $display("FAIL reset_we: got %b want 0", lw[1]); end
    reset = 1'b0;
    cyc = 0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n_cmp++; if (lgv[0] !== 1'b0)   begin n_bad++; $display("FAIL reset_bubble: got gv=%b want 0", lgv[0]); end
    n_cmp++; if (lgv[1] !== 1'b1 || lgi[1] !== 2'd0) begin
      n_bad++; $display("FAIL reset_first_grant: got gv=%b idx=%0d want gv=1 idx=0", lgv[1], lgi[1]);
    end
  endtask

  task automatic test_rotation();
    clear_q();
    for (int i = 0; i < R; i++) begin add_pkt(i, 1, 8'h10 + 8'(i)); add_pkt(i, 1, 8'h10 + 8'(i)); end
    do_reset(2);
    repeat (11) cycle(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (lw[2*k] !== 1'b0) begin n_bad++; $display("FAIL rot_bubble%0d: got we=%b want 0", k, lw[2*k]); end
      n_cmp++;
      if (lw[2*k+1] !== 1'b1 || ld[2*k+1] !== 8'h10 + 8'(k % 4)) begin
        n_bad++; $display("FAIL rot_write%0d: got we=%b data=%h want we=1 data=%h", k, lw[2*k+1], ld[2*k+1], 8'h10 + 8'(k % 4));
      end
    end
  endtask

  task automatic test_lock();
    clear_q();
    add_pkt(0, 3, 8'hA0);
    add_pkt(1, 1, 8'hB0);
    do_reset(2);
    repeat (7) cycle(1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (lw[c] !== 1'b1 || ld[c] !== 8'hA0 + 8'(c - 1) || lgi[c] !== 2'd0 || lrdy[c][1] !== 1'b0) begin
        n_bad++; $display("FAIL lock_beat%0d: got we=%b data=%h idx=%0d rdy=%b want we=1 data=%h idx=0 rdy[1]=0",
                          c - 1, lw[c], ld[c], lgi[c], lrdy[c], 8'hA0 + 8'(c - 1));
      end
    end
    n_cmp++; if (lw[4] !== 1'b0 || lgv[4] !== 1'b0) begin
      n_bad++; $display("FAIL lock_bubble: got we=%b gv=%b want 0 0", lw[4], lgv[4]);
    end
    n_cmp++; if (lw[5] !== 1'b1 || ld[5] !== 8'hB0 || lgi[5] !== 2'd1) begin
      n_bad++; $display("FAIL lock_next: got we=%b data=%h idx=%0d want we=1 data=b0 idx=1", lw[5], ld[5], lgi[5]);
    end
  endtask

  task automatic test_full();
    clear_q();
    add_pkt(0, 3, 8'hC0);
    do_reset(2);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int c = 3; c <= 5; c++) begin
      n_cmp++;
      if (lw[c] !== 1'b0 || lrdy[c] !== 4'b0 || lgv[c] !== 1'b1) begin
        n_bad++; $display("FAIL full_hold%0d: got we=%b rdy=%b gv=%b want 0 0000 1", c, lw[c], lrdy[c], lgv[c]);
      end
    end
    n_cmp++; if (lw[6] !== 1'b1 || ld[6] !== 8'hC2) begin
      n_bad++; $display("FAIL full_resume: got we=%b data=%h want we=1 data=c2", lw[6], ld[6]);
    end
  endtask

  task automatic test_flush();
    clear_q();
    add_pkt(2, 3, 8'h20);
    do_reset(2);
    cycle(1'b0, 1'b0);
    add_pkt(0, 1, 8'h05);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n_cmp++; if (lw[1] !== 1'b1 || lgi[1] !== 2'd2 || ld[1] !== 8'h20) begin
      n_bad++; $display("FAIL flush_pre: got we=%b idx=%0d data=%h want 1 2 20", lw[1], lgi[1], ld[1]);
    end
    n_cmp++; if (lw[2] !== 1'b0 || lrdy[2] !== 4'b0) begin
      n_bad++; $display("FAIL flush_cycle: got we=%b rdy=%b want 0 0000", lw[2], lrdy[2]);
    end
    n_cmp++; if (lgv[3] !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got gv=%b want 0", lgv[3]); end
    n_cmp++; if (lw[4] !== 1'b1 || lgi[4] !== 2'd0 || ld[4] !== 8'h05) begin
      n_bad++; $display("FAIL flush_regrant: got we=%b idx=%0d data=%h want 1 0 05", lw[4], lgi[4], ld[4]);
    end
  endtask

  task automatic test_r3();
    int seq [16];
    int ns;
    ns = 0;
    clear_q();
    v3 = 3'b111; l3 = 3'b111; d3 = {8'h32, 8'h31, 8'h30};
    do_reset(2);
    for (int c = 0; c < 12; c++) begin
      #5;
      n_cmp++;
      if (gi3 > 2'd2) begin n_bad++; $display("FAIL r3_range: got idx=%0d want <3", gi3); end
      if (we3 && ns < 16) begin seq[ns] = int'(gi3); ns++; end
      @(posedge clock); #1;
    end
    v3 = 3'b000;
    n_cmp++; if (ns < 4) begin n_bad++; $display("FAIL r3_count: got %0d grants want >=4", ns); end
    for (int k = 0; k < 4 && k < ns; k++) begin
      n_cmp++;
      if (seq[k] != k % 3) begin n_bad++; $display("FAIL r3_seq%0d: got %0d want %0d", k, seq[k], k % 3); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d [512];
    int         exp_i [512];
    logic [7:0] obs_d [512];
    int         obs_i [512];
    int mh [R];
    int exp_n, obs_n, ptr, r, guard;
    bit found, done, busy;
    for (int round = 0; round < 4; round++) begin
      clear_q();
      for (int i = 0; i < R; i++) begin
        int npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) add_pkt(i, int'($urandom_range(1, 4)), 8'($urandom));
      end
      // Packet-level model: each packet goes whole to the next busy requester after the last winner
      for (int i = 0; i < R; i++) mh[i] = 0;
      exp_n = 0; ptr = 0;
      forever begin
        found = 1'b0; r = 0;
        for (int k = 0; k < R; k++) begin
          if (!found && mh[(ptr + k) % R] < bn[(ptr + k) % R]) begin found = 1'b1; r = (ptr + k) % R; end
        end
        if (!found) break;
        done = 1'b0;
        while (!done) begin
          exp_d[exp_n] = bd[r][mh[r]]; exp_i[exp_n] = r; exp_n++;
          done = bl[r][mh[r]]; mh[r]++;
        end
        ptr = (r + 1) % R;
      end
      do_reset(2);
      obs_n = 0; guard = 0;
      busy = 1'b1;
      while (busy && guard < 400) begin
        cycle($urandom_range(0, 3) == 0, 1'b0);
        if (last_we && obs_n < 512) begin obs_d[obs_n] = last_d; obs_i[obs_n] = int'(last_gi); obs_n++; end
        guard++;
        busy = 1'b0;
        for (int i = 0; i < R; i++) if (bh[i] < bn[i]) busy = 1'b1;
      end
      n_cmp++; if (busy) begin n_bad++; $display("FAIL rnd_timeout%0d: got pending beats after %0d cycles want none", round, guard); end
      n_cmp++; if (obs_n != exp_n) begin n_bad++; $display("FAIL rnd_count%0d: got %0d writes want %0d", round, obs_n, exp_n); end
      for (int k = 0; k < exp_n && k < obs_n; k++) begin
        n_cmp++;
        if (obs_d[k] !== exp_d[k] || obs_i[k] != exp_i[k]) begin
          n_bad++; $display("FAIL rnd_beat%0d_%0d: got data=%h idx=%0d want data=%h idx=%0d",
                            round, k, obs_d[k], obs_i[k], exp_d[k], exp_i[k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fifo_full = 1'b0;
    request_valid = '0; request_last = '0; request_data = '0;
    v3 = 3'b000; l3 = 3'b000; d3 = 24'h0;
    cyc = 0;
    @(posedge clock); #1;
    test_reset();
    test_rotation();
    test_lock();
    test_full();
    test_flush();
    test_r3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
